// File: rtl/reg_write_demux_16_if.sv
// Write-back request channel for the register file.
// Carries rd/data with a valid/ready handshake.
interface reg_write_demux_16_if #(
  parameter int WIDTH = 16
);
  logic             wr_valid;
  logic             wr_ready;
  logic [3:0]       wr_rd;
  logic [WIDTH-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_rd,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_rd,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/reg_write_demux_16.sv
// Write side of the 16-entry register file: FIFO, rd decode, x0..x15.
// Optional X0_ZERO_EN: x0 hardwired to zero, rd=0 commits are dropped.
module reg_write_demux_16 #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_write_demux_16_if.slave  wr,
  input  logic                 rf_hold,
  output logic [15:0]          wr_en_1hot,
  output logic [15:0]          pend_mask,
  output logic [16*WIDTH-1:0]  regs_flat,
  output logic [2:0]           fifo_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]       r_rd   [DEPTH];
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [2:0]       r_count;
  logic [WIDTH-1:0] r_x    [16];
  logic [15:0]      r_en;

  logic             w_push;
  logic             w_pop;
  logic [3:0]       w_head_rd;
  logic [WIDTH-1:0] w_head_data;
  logic             w_wr_x;

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr.wr_ready = (r_count < 3'(DEPTH));
  assign w_push      = wr.wr_valid & wr.wr_ready;
  assign w_pop       = !rf_hold && (r_count != 3'd0);
  assign w_head_rd   = r_rd[r_head];
  assign w_head_data = r_data[r_head];
  assign fifo_count  = r_count;
  assign wr_en_1hot  = r_en;

`ifdef X0_ZERO_EN
  assign w_wr_x = (w_head_rd != 4'd0);
`else
  assign w_wr_x = 1'b1;
`endif

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= f_inc(r_head);
      end
      if (w_push) begin
        r_rd[r_tail]   <= wr.wr_rd;
        r_data[r_tail] <= wr.wr_data;
        r_vld[r_tail]  <= 1'b1;
        r_tail         <= f_inc(r_tail);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Commit the head entry into the register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_x[i] <= '0;
      r_en <= '0;
    end else if (w_pop) begin
      if (w_wr_x) begin
        r_x[w_head_rd] <= w_head_data;
        r_en           <= 16'h1 << w_head_rd;
      end else begin
        r_en <= '0;
      end
    end else begin
      r_en <= '0;
    end
  end

  // Pending mask: OR-decode of rd over all live entries
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (r_vld[i]) pend_mask[r_rd[i]] = 1'b1;
  end

  for (genvar g = 0; g < 16; g++) begin : g_flat
`ifdef X0_ZERO_EN
    if (g == 0) begin : g_zero
      assign regs_flat[g*WIDTH +: WIDTH] = '0;
    end else begin : g_reg
      assign regs_flat[g*WIDTH +: WIDTH] = r_x[g];
    end
`else
    assign regs_flat[g*WIDTH +: WIDTH] = r_x[g];
`endif
  end

endmodule

// File: tb/tb_reg_write_demux_16.sv
// Bench for reg_write_demux_16: directed scenarios plus random traffic
// compared against a queue-based model of the write path.
module tb_reg_write_demux_16;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                rf_hold;
  logic [15:0]         wr_en_1hot;
  logic [15:0]         pend_mask;
  logic [16*WIDTH-1:0] regs_flat;
  logic [2:0]          fifo_count;

  reg_write_demux_16_if #(.WIDTH(WIDTH)) wr ();

  reg_write_demux_16 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr),
    .rf_hold    (rf_hold),
    .wr_en_1hot (wr_en_1hot),
    .pend_mask  (pend_mask),
    .regs_flat  (regs_flat),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [19:0] m_q[$];
  logic [15:0] m_x [16];
  logic [15:0] m_en;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    m_q.delete();
    for (int i = 0; i < 16; i++) m_x[i] = '0;
    m_en = '0;
  endtask

  // Model of one clock edge, using the inputs held before the edge
  task automatic m_edge(input bit v, input logic [3:0] rd,
                        input logic [15:0] d, input bit h);
    bit rdy;
    logic [19:0] e;
    rdy  = (m_q.size() < DEPTH);
    m_en = '0;
    if (!h && m_q.size() > 0) begin
      e = m_q.pop_front();
`ifdef X0_ZERO_EN
      if (e[19:16] != 4'd0) begin
        m_x[e[19:16]] = e[15:0];
        m_en = 16'h1 << e[19:16];
      end
`else
      m_x[e[19:16]] = e[15:0];
      m_en = 16'h1 << e[19:16];
`endif
    end
    if (v && rdy) m_q.push_back({rd, d});
  endtask

  task automatic check_all();
    logic [15:0] pm;
    pm = '0;
    foreach (m_q[i]) pm[m_q[i][19:16]] = 1'b1;
    chk("count", 32'(fifo_count), 32'(m_q.size()));
    chk("ready", 32'(wr.wr_ready), 32'(m_q.size() < DEPTH));
    chk("pend", 32'(pend_mask), 32'(pm));
    chk("en1hot", 32'(wr_en_1hot), 32'(m_en));
    for (int i = 0; i < 16; i++)
      chk($sformatf("x%0d", i), 32'(regs_flat[i*WIDTH +: WIDTH]),
          32'(m_x[i]));
  endtask

  task automatic step(input bit v, input logic [3:0] rd,
                      input logic [15:0] d, input bit h);
    wr.wr_valid = v;
    wr.wr_rd    = rd;
    wr.wr_data  = d;
    rf_hold     = h;
    @(posedge clk);
    m_edge(v, rd, d, h);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    wr.wr_valid = 1'b0;
    #2 rst = 1'b1;
    m_clear();
    #1 check_all();
    @(posedge clk);
    #1 check_all();
    rst = 1'b0;
  endtask

  initial begin
    bit          v;
    logic [3:0]  rd;
    logic [15:0] d;
    bit          h;
    bit          hold_req;

    rst = 1'b1;
    rf_hold = 1'b0;
    wr.wr_valid = 1'b0;
    wr.wr_rd = '0;
    wr.wr_data = '0;
    m_clear();
    #12 check_all();
    rst = 1'b0;
    @(posedge clk);
    #1 check_all();

    // T2 single write
    step(1, 4'd5, 16'hBEEF, 0);
    step(0, 4'd0, 16'h0, 0);
    step(0, 4'd0, 16'h0, 0);

    // T3 full, held third request, release
    step(1, 4'd1, 16'h0001, 1);
    step(1, 4'd2, 16'h0002, 1);
    chk("t3_pend", 32'(pend_mask), 32'h0006);
    step(1, 4'd7, 16'h0007, 1);
    step(1, 4'd7, 16'h0007, 0);
    step(1, 4'd7, 16'h0007, 0);
    step(0, 4'd0, 16'h0, 0);
    step(0, 4'd0, 16'h0, 0);
    step(0, 4'd0, 16'h0, 0);

    // T4 same rd back-to-back
    step(1, 4'd3, 16'h1111, 0);
    step(1, 4'd3, 16'h2222, 0);
    step(0, 4'd0, 16'h0, 0);
    step(0, 4'd0, 16'h0, 0);
    chk("t4_x3", 32'(regs_flat[3*WIDTH +: WIDTH]), 32'h2222);

    // T5 streaming with count=1, all rd indices
    step(1, 4'd0, 16'hA000, 1);
    for (int i = 1; i < 20; i++)
      step(1, 4'(i), 16'hA000 + 16'(i), 0);
    step(0, 4'd0, 16'h0, 0);
    step(0, 4'd0, 16'h0, 0);

    // T6 rd=0 write of FFFF
    step(1, 4'd0, 16'hFFFF, 0);
    step(0, 4'd0, 16'h0, 0);
`ifdef X0_ZERO_EN
    chk("t6_en", 32'(wr_en_1hot), 32'h0000);
    chk("t6_x0", 32'(regs_flat[WIDTH-1:0]), 32'h0000);
`else
    chk("t6_en", 32'(wr_en_1hot), 32'h0001);
    chk("t6_x0", 32'(regs_flat[WIDTH-1:0]), 32'hFFFF);
`endif

    // T1 reset with two entries queued
    step(1, 4'd9, 16'h9999, 1);
    step(1, 4'd10, 16'hAAAA, 1);
    do_reset();
    chk("t1_count", 32'(fifo_count), 32'd0);
    chk("t1_ready", 32'(wr.wr_ready), 32'd1);
    chk("t1_pend", 32'(pend_mask), 32'd0);

    // Random traffic; unaccepted requests are held stable
    hold_req = 0;
    v = 0; rd = '0; d = '0;
    for (int n = 0; n < 600; n++) begin
      if (!hold_req) begin
        v  = ($urandom_range(0, 3) != 0);
        rd = 4'($urandom_range(0, 15));
        d  = 16'($urandom);
      end
      h = ($urandom_range(0, 3) == 0);
      hold_req = v && !(m_q.size() < DEPTH);
      step(v, rd, d, h);
      if (n == 300) do_reset();
      if (n == 300) hold_req = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
